ii_buffer_scheduler: RTL and testbench
======================================

II_BUFFER_SCHEDULER -- requirements
Module: ii_buffer_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, integral-image buffer address width.
REQ-002 SHALL have parameter DATA_W, default 32, integral-image word width.
REQ-003 SHALL have parameter RD_LAT, default 2, buffer port-B read latency in cycles.
REQ-004 SHALL have parameter CAP_TIMEOUT, default 1048576, maximum CAPTURE duration in cycles.
REQ-005 SHALL have parameter STARVE_MAX, default 64, maximum consecutive detector denials.
REQ-006 SHALL have ports in this order:
- clk_vga  in  1  sole clock.
- rst  in  1  reset, asynchronous and active-high.
- frame_req  in  1  request a new capture, level.
- cap_done  in  1  capture-complete pulse, synchronous to clk_vga.
- cap_en  out  1  capture writer enable.
- wr_sel  out  1  buffer port-A enable.
- disp_req  in  1  display read request.
- disp_addr  in  ADDR_W  display read address.
- disp_gnt  out  1  display granted this cycle.
- det_req  in  1  detector read request.
- det_addr  in  ADDR_W  detector read address.
- det_gnt  out  1  detector granted this cycle.
- bram_addrb  out  ADDR_W  buffer port-B address.
- bram_doutb  in  DATA_W  buffer port-B data.
- rd_data  out  DATA_W  broadcast read data.
- disp_valid  out  1  rd_data belongs to display.
- det_valid  out  1  rd_data belongs to detector.
- frame_cnt  out  8  completed-capture count.
- cap_err  out  1  one-cycle capture-timeout pulse.

Function
REQ-007 SHALL implement a three-state FSM: IDLE, CAPTURE, READ.
REQ-008 IDLE SHALL go to CAPTURE when frame_req=1.
REQ-009 CAPTURE SHALL go to READ on cap_done=1.
REQ-010 CAPTURE SHALL go to IDLE and pulse cap_err when the in-state cycle counter reaches CAP_TIMEOUT-1 without cap_done; cap_done SHALL win when both occur in the same cycle.
REQ-011 READ SHALL go to CAPTURE when frame_req=1 and no read is in flight; until then, new grants SHALL be suppressed (drain).
REQ-012 cap_en and wr_sel SHALL be registered, 1 exactly while in CAPTURE, and 0 otherwise.
REQ-013 Grants SHALL be combinational and issued only in READ, not while draining; at most one grant per cycle.
REQ-014 Display SHALL have strict priority, except when the starvation counter equals STARVE_MAX; then the detector SHALL be granted if det_req=1.
REQ-015 Starvation counter SHALL increment per cycle with det_req=1 and det_gnt=0, saturate at STARVE_MAX, and clear on det_gnt or det_req=0.
REQ-016 bram_addrb SHALL be the granted requester's address, else hold its previous value.
REQ-017 A grant in cycle N SHALL assert the matching disp_valid/det_valid in cycle N+RD_LAT with rd_data=bram_doutb; both valids SHALL never be 1 together.
REQ-018 frame_cnt SHALL increment by 1 on each accepted cap_done, wrapping 255->0.
REQ-019 cap_done outside CAPTURE SHALL be ignored.

Reset
REQ-020 rst=1 SHALL force IDLE immediately; cap_en=0, wr_sel=0, frame_cnt=0, cap_err=0, disp_valid=det_valid=0, bram_addrb=0, starvation and timeout counters 0, and clear in-flight tags.
REQ-021 Reset mid-read SHALL discard all in-flight reads with no valid pulse after release.

Structure
REQ-022 ADDR_W, DATA_W and FSM state encodings SHALL live in the shared package ii_defs.
REQ-023 The RD_LAT-deep owner-tag shift register SHALL be the sub-module ii_rd_tag_pipe.

Verification
REQ-024 Bench SHALL cover these scenarios:
- rst release, frame_req=1 for 1 cycle -> cap_en=1 next cycle; cap_done after 100 cycles -> READ, cap_en=0, frame_cnt=1.
- READ, disp_req and det_req both 1 with addresses 5 and 9 -> bram_addrb=5, disp_valid 2 cycles later carrying word 5; detector granted on cycle 65, addr 9.
- CAP_TIMEOUT=16, no cap_done -> cap_err pulse at cycle 16, IDLE, frame_cnt unchanged.
- READ with 2 reads in flight, frame_req=1 -> no new grants, both valids delivered, then cap_en=1.
- rst asserted one cycle after a grant -> no valid pulse; all outputs at reset values asynchronously.
- 256 capture cycles -> frame_cnt wraps to 0; cap_done in READ -> no count change.

Source files
------------

// File: rtl/ii_defs.sv
// Shared widths, FSM state encoding and read-owner tag type for the integral-image
// buffer scheduler.
package ii_defs;

    localparam int unsigned II_ADDR_W = 15;
    localparam int unsigned II_DATA_W = 32;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StRead    = 2'd2
    } ii_state_e;

    typedef struct packed {
        logic disp;
        logic det;
    } rd_tag_t;

endpackage

// File: rtl/ii_rd_tag_pipe.sv
// Owner-tag delay line: follows each port-B read through the buffer latency so the
// returning word can be attributed to display or detector.
module ii_rd_tag_pipe
    import ii_defs::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk_vga,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out,
    output logic    busy
);

    rd_tag_t stage_q [DEPTH];

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        tag_out = stage_q[DEPTH-1];
        busy    = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            busy = busy | stage_q[i].disp | stage_q[i].det;
        end
    end

endmodule

// File: rtl/ii_buffer_scheduler.sv
// Sequences capture and read phases of the integral-image buffer and arbitrates
// port-B reads between display and detector.
module ii_buffer_scheduler
    import ii_defs::*;
#(
    parameter int unsigned ADDR_W      = II_ADDR_W,
    parameter int unsigned DATA_W      = II_DATA_W,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned CAP_TIMEOUT = 1048576,
    parameter int unsigned STARVE_MAX  = 64
) (
    input  logic              clk_vga,
    input  logic              rst,
    input  logic              frame_req,
    input  logic              cap_done,
    output logic              cap_en,
    output logic              wr_sel,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    input  logic              det_req,
    input  logic [ADDR_W-1:0] det_addr,
    output logic              det_gnt,
    output logic [ADDR_W-1:0] bram_addrb,
    input  logic [DATA_W-1:0] bram_doutb,
    output logic [DATA_W-1:0] rd_data,
    output logic              disp_valid,
    output logic              det_valid,
    output logic [7:0]        frame_cnt,
    output logic              cap_err
);

    localparam int unsigned CW = (CAP_TIMEOUT > 1) ? $clog2(CAP_TIMEOUT) : 1;
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CAP_LAST    = CW'(CAP_TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX);

    ii_state_e         state_q;
    logic [CW-1:0]     cap_cnt_q;
    logic [SW-1:0]     starve_q;
    logic [ADDR_W-1:0] addr_q;
    rd_tag_t           tag_in;
    rd_tag_t           tag_out;
    logic              busy;

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cap_en    <= 1'b0;
            wr_sel    <= 1'b0;
            cap_err   <= 1'b0;
            frame_cnt <= 8'd0;
            cap_cnt_q <= '0;
        end else begin
            cap_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (frame_req) begin
                        state_q   <= StCapture;
                        cap_en    <= 1'b1;
                        wr_sel    <= 1'b1;
                        cap_cnt_q <= '0;
                    end
                end
                StCapture: begin
                    // cap_done takes precedence over a coincident timeout
                    if (cap_done) begin
                        state_q   <= StRead;
                        cap_en    <= 1'b0;
                        wr_sel    <= 1'b0;
                        frame_cnt <= frame_cnt + 8'd1;
                    end else if (cap_cnt_q == CAP_LAST) begin
                        state_q <= StIdle;
                        cap_en  <= 1'b0;
                        wr_sel  <= 1'b0;
                        cap_err <= 1'b1;
                    end else begin
                        cap_cnt_q <= cap_cnt_q + 1'b1;
                    end
                end
                StRead: begin
                    if (frame_req && !busy) begin
                        state_q   <= StCapture;
                        cap_en    <= 1'b1;
                        wr_sel    <= 1'b1;
                        cap_cnt_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // A pending frame_req in READ blocks new grants so in-flight reads can drain
    always_comb begin
        disp_gnt   = 1'b0;
        det_gnt    = 1'b0;
        bram_addrb = addr_q;
        if (state_q == StRead && !frame_req) begin
            if (det_req && (starve_q == STARVE_LAST || !disp_req)) begin
                det_gnt    = 1'b1;
                bram_addrb = det_addr;
            end else if (disp_req) begin
                disp_gnt   = 1'b1;
                bram_addrb = disp_addr;
            end
        end
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
            addr_q   <= '0;
        end else begin
            addr_q <= bram_addrb;
            if (det_req && !det_gnt) begin
                starve_q <= (starve_q == STARVE_LAST) ? starve_q : starve_q + 1'b1;
            end else begin
                starve_q <= '0;
            end
        end
    end

    always_comb begin
        tag_in.disp = disp_gnt;
        tag_in.det  = det_gnt;
        disp_valid  = tag_out.disp;
        det_valid   = tag_out.det;
        rd_data     = bram_doutb;
    end

    ii_rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_tag_pipe (
        .clk_vga (clk_vga),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .busy    (busy)
    );

endmodule

// File: tb/tb_ii_buffer_scheduler.sv
// Self-checking bench: cycle-level reference model plus directed and random stimulus.
module tb_ii_buffer_scheduler;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 32;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned CAP_TO = 128;
    localparam int unsigned SMAX = 64;

    logic          clk_vga = 1'b0;
    logic          rst = 1'b1;
    logic          frame_req = 1'b0, cap_done = 1'b0;
    logic          cap_en, wr_sel;
    logic          disp_req = 1'b0, det_req = 1'b0;
    logic [AW-1:0] disp_addr = '0, det_addr = '0;
    logic          disp_gnt, det_gnt;
    logic [AW-1:0] bram_addrb;
    logic [DW-1:0] bram_doutb, rd_data;
    logic          disp_valid, det_valid;
    logic [7:0]    frame_cnt;
    logic          cap_err;

    // Second instance with a short timeout
    logic          t_rst = 1'b1, t_frame_req = 1'b0, t_cap_done = 1'b0;
    logic          t_cap_en, t_wr_sel, t_disp_gnt, t_det_gnt, t_disp_valid, t_det_valid, t_cap_err;
    logic [AW-1:0] t_bram_addrb;
    logic [DW-1:0] t_rd_data;
    logic [7:0]    t_frame_cnt;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk_vga = ~clk_vga;

    ii_buffer_scheduler #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .CAP_TIMEOUT(CAP_TO), .STARVE_MAX(SMAX)
    ) u_dut (
        .clk_vga(clk_vga), .rst(rst), .frame_req(frame_req), .cap_done(cap_done),
        .cap_en(cap_en), .wr_sel(wr_sel), .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_gnt(disp_gnt), .det_req(det_req), .det_addr(det_addr), .det_gnt(det_gnt),
        .bram_addrb(bram_addrb), .bram_doutb(bram_doutb), .rd_data(rd_data),
        .disp_valid(disp_valid), .det_valid(det_valid), .frame_cnt(frame_cnt),
        .cap_err(cap_err)
    );

    ii_buffer_scheduler #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .CAP_TIMEOUT(16), .STARVE_MAX(SMAX)
    ) u_to (
        .clk_vga(clk_vga), .rst(t_rst), .frame_req(t_frame_req), .cap_done(t_cap_done),
        .cap_en(t_cap_en), .wr_sel(t_wr_sel), .disp_req(1'b0), .disp_addr('0),
        .disp_gnt(t_disp_gnt), .det_req(1'b0), .det_addr('0), .det_gnt(t_det_gnt),
        .bram_addrb(t_bram_addrb), .bram_doutb('0), .rd_data(t_rd_data),
        .disp_valid(t_disp_valid), .det_valid(t_det_valid), .frame_cnt(t_frame_cnt),
        .cap_err(t_cap_err)
    );

    // Buffer model: word content is a function of its address, RD_LAT cycles late
    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | {17'd0, a};
    endfunction

    logic [AW-1:0] ap [RD_LAT];
    always @(posedge clk_vga) begin
        ap[0] <= bram_addrb;
        for (int i = 1; i < int'(RD_LAT); i++) ap[i] <= ap[i-1];
    end
    assign bram_doutb = word_of(ap[RD_LAT-1]);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_vga);
        #1;
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        bit            is_det;
        logic [AW-1:0] addr;
    } rd_t;

    rd_t           pend[$];
    int            cyc = 0;
    int            m_mode = 0;      // 0 idle, 1 capture, 2 read
    int            m_cap_start = 0;
    int            m_frames = 0;
    bit            m_err = 0;
    int            m_starve = 0;
    logic [AW-1:0] m_addr = '0;

    initial begin
        forever begin
            bit            e_dg, e_tg, e_dv, e_tv, in_flight, drive;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_word;
            @(negedge clk_vga);
            cyc++;
            if (rst) begin
                pend.delete();
                m_mode = 0; m_frames = 0; m_err = 0; m_starve = 0; m_addr = '0;
            end
            drive = (m_mode == 2) && !frame_req;
            e_tg = drive && det_req && (m_starve >= int'(SMAX) || !disp_req);
            e_dg = drive && disp_req && !e_tg;
            e_addr = e_tg ? det_addr : (e_dg ? disp_addr : m_addr);
            e_dv = 0; e_tv = 0; e_word = '0; in_flight = 0;
            foreach (pend[i]) begin
                if (pend[i].due == cyc) begin
                    e_dv = !pend[i].is_det; e_tv = pend[i].is_det; e_word = word_of(pend[i].addr);
                end
                if (pend[i].due >= cyc) in_flight = 1;
            end
            check("cap_en", cap_en, m_mode == 1);
            check("wr_sel", wr_sel, m_mode == 1);
            check("cap_err", cap_err, m_err);
            check("frame_cnt", frame_cnt, m_frames % 256);
            check("disp_gnt", disp_gnt, e_dg);
            check("det_gnt", det_gnt, e_tg);
            check("bram_addrb", bram_addrb, e_addr);
            check("disp_valid", disp_valid, e_dv);
            check("det_valid", det_valid, e_tv);
            if (e_dv || e_tv) check("rd_data", rd_data, e_word);
            if (!rst) begin
                m_starve = (det_req && !e_tg) ? ((m_starve < int'(SMAX)) ? m_starve + 1 : m_starve) : 0;
                if (e_dg || e_tg) pend.push_back('{due: cyc + int'(RD_LAT), is_det: e_tg, addr: e_addr});
                m_addr = e_addr;
                m_err = 0;
                case (m_mode)
                    0: if (frame_req) begin m_mode = 1; m_cap_start = cyc + 1; end
                    1: begin
                        if (cap_done) begin
                            m_mode = 2; m_frames++;
                        end else if (cyc - m_cap_start == int'(CAP_TO) - 1) begin
                            m_mode = 0; m_err = 1;
                        end
                    end
                    default: if (frame_req && !in_flight) begin m_mode = 1; m_cap_start = cyc + 1; end
                endcase
                while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k, nv;
        bit found;
        #2;
        check("rst cap_en", cap_en, 0);
        check("rst frame_cnt", frame_cnt, 0);
        check("rst bram_addrb", bram_addrb, 0);
        step(); step();
        rst = 1'b0;
        step();

        // Capture start and completion after 100 cycles
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        check("cap_en after req", cap_en, 1);
        repeat (99) step();
        cap_done = 1'b1;
        step();
        cap_done = 1'b0;
        check("cap_en after done", cap_en, 0);
        check("frame_cnt after done", frame_cnt, 1);

        // Display priority, then starvation override on the 65th cycle
        disp_req = 1'b1; det_req = 1'b1; disp_addr = 15'd5; det_addr = 15'd9;
        #1;
        check("first grant disp", disp_gnt, 1);
        check("first addr", bram_addrb, 5);
        step(); step();
        check("disp_valid word5", disp_valid, 1);
        check("rd_data word5", rd_data, 32'hC0DE_0005);
        k = 2; found = 0;
        while (k < 100) begin
            if (det_gnt) begin found = 1; break; end
            step(); k++;
        end
        check("det grant found", found, 1);
        check("det grant cycle", k, 64);
        check("det addr", bram_addrb, 9);
        step();
        check("disp regains", disp_gnt, 1);
        disp_req = 1'b0; det_req = 1'b0;
        repeat (4) step();

        // Drain: two reads in flight, then frame_req
        disp_req = 1'b1; disp_addr = 15'd20;
        step();
        disp_addr = 15'd21;
        step();
        frame_req = 1'b1;
        #1;
        check("drain no grant", disp_gnt, 0);
        nv = 0; found = 0;
        for (int i = 0; i < 10; i++) begin
            if (disp_valid) nv++;
            if (cap_en) begin found = 1; break; end
            step();
        end
        check("drain valids", nv, 2);
        check("drain to capture", found, 1);
        frame_req = 1'b0; disp_req = 1'b0;
        step();
        cap_done = 1'b1;
        step();
        cap_done = 1'b0;
        check("frame_cnt 2", frame_cnt, 2);

        // Reset one cycle after a grant
        disp_req = 1'b1; disp_addr = 15'd7;
        step();
        disp_req = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst cap_en", cap_en, 0);
        check("arst frame_cnt", frame_cnt, 0);
        check("arst bram_addrb", bram_addrb, 0);
        check("arst disp_valid", disp_valid, 0);
        step();
        rst = 1'b0;
        step();
        check("no stale valid", disp_valid, 0);
        step();
        check("no stale valid 2", disp_valid, 0);

        // 256 captures wrap frame_cnt
        for (int i = 0; i < 256; i++) begin
            frame_req = 1'b1;
            step();
            frame_req = 1'b0;
            step();
            cap_done = 1'b1;
            step();
            cap_done = 1'b0;
            step();
            if (i == 254) check("frame_cnt 255", frame_cnt, 255);
        end
        check("frame_cnt wrap", frame_cnt, 0);
        cap_done = 1'b1;
        step();
        cap_done = 1'b0;
        check("cap_done in READ ignored", frame_cnt, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            frame_req = ($urandom_range(0, 99) < 8);
            cap_done  = ($urandom_range(0, 99) < 2);
            disp_req  = $urandom_range(0, 1);
            det_req   = ($urandom_range(0, 3) != 0);
            disp_addr = AW'($urandom);
            det_addr  = AW'($urandom);
            step();
        end
        frame_req = 0; cap_done = 0; disp_req = 0; det_req = 0;
        repeat (4) step();

        // Short-timeout instance
        t_rst = 1'b0;
        step();
        t_frame_req = 1'b1;
        step();
        t_frame_req = 1'b0;
        check("t cap_en", t_cap_en, 1);
        k = 0;
        while (!t_cap_err && k < 40) begin step(); k++; end
        check("t timeout cycle", k, 16);
        check("t cap_en off", t_cap_en, 0);
        check("t frame_cnt", t_frame_cnt, 0);
        step();
        check("t cap_err pulse", t_cap_err, 0);
        t_frame_req = 1'b1;
        step();
        t_frame_req = 1'b0;
        repeat (15) step();
        t_cap_done = 1'b1;
        step();
        t_cap_done = 1'b0;
        check("t done wins err", t_cap_err, 0);
        check("t done wins cnt", t_frame_cnt, 1);
        check("t done wins cap_en", t_cap_en, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
